batalha_ctrl: RTL and testbench

Game-phase controller for the naval-battle datapath: it sequences the position-matrix load, attack-matrix cell writes and matrix clears from the confirmation button, the mode switches and the coordinate switches. It debounces the raw button and validates each shot against the 7-row × 5-column grid. It keeps shot and hit counters and declares win/loss. It sits between the board I/O and the position/attack register matrices, replacing their direct button/demux clocking with single-cycle, same-clock write strobes.

---
 rtl/pbl_pkg.sv | 28 ++
 rtl/btn_debounce.sv | 72 +++++++
 rtl/batalha_ctrl.sv | 131 +++++++++++++
 tb/tb_batalha_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pbl_pkg.sv
// pbl_pkg -- shared codes for the naval-battle game controller.
//   state_t   : FSM state codes, also driven out as `phase`
//   MODE_*    : 2-bit phase request codes from the mode switches
//   RES_*     : 2-bit last-shot result codes
//   ROW_MAX / COL_MAX : highest valid row / column of the 7x5 grid
package pbl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PLACED = 3'd1,
        WIN    = 3'd2,
        LOSE   = 3'd3
    } state_t;

    localparam logic [1:0] MODE_CLR = 2'b00;
    localparam logic [1:0] MODE_POS = 2'b01;
    localparam logic [1:0] MODE_AT  = 2'b10;
    localparam logic [1:0] MODE_RSV = 2'b11;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_MISS = 2'b01;
    localparam logic [1:0] RES_HIT  = 2'b10;
    localparam logic [1:0] RES_REJ  = 2'b11;

    localparam logic [2:0] ROW_MAX = 3'd6;
    localparam logic [2:0] COL_MAX = 3'd4;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce -- turns the raw confirmation button into a one-cycle pulse.
// Build option: DEBOUNCE_EN
//   defined   : 2-flop sync, DEB_CYCLES-cycle stability filter, edge detect;
//               press is high in cycle 2+DEB_CYCLES+1 after a clean edge.
//   undefined : filter bypassed; press 3 cycles after the input edge.
// Ports:
//   clk      in  system clock
//   Nclr     in  asynchronous active-low reset
//   btn_raw  in  raw asynchronous active-high button
//   press    out registered one-cycle pulse per debounced rising edge
module btn_debounce #(
    parameter int DEB_CYCLES = 65536
) (
    input  logic clk,
    input  logic Nclr,
    input  logic btn_raw,
    output logic press
);

    logic sync_a;
    logic sync_b;
    logic level;
    logic level_d;

    always_ff @(posedge clk or negedge Nclr) begin
        if (!Nclr) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make the two flops a real
            // shift chain; blocking ones would collapse it to one stage.
            sync_a <= btn_raw;
            sync_b <= sync_a;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);

    logic [CW-1:0] stable_cnt;

    // The level follows the synchronized button only after it has
    // disagreed with the level for DEB_CYCLES consecutive cycles; any
    // bounce back to agreement restarts the count.
    always_ff @(posedge clk or negedge Nclr) begin
        if (!Nclr) begin
            level      <= 1'b0;
            stable_cnt <= '0;
        end else if (sync_b == level) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CW'(DEB_CYCLES - 1)) begin
            level      <= sync_b;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end
`else
    assign level = sync_b;
`endif

    always_ff @(posedge clk or negedge Nclr) begin
        if (!Nclr) begin
            level_d <= 1'b0;
            press   <= 1'b0;
        end else begin
            level_d <= level;
            press   <= level & ~level_d;
        end
    end

endmodule

// File: rtl/batalha_ctrl.sv
// batalha_ctrl -- game-phase controller for the naval-battle datapath.
// Build option: DEBOUNCE_EN (selects the button stability filter).
// Ports:
//   clk, Nclr            clock, asynchronous active-low reset
//   button_confirmation  raw confirmation button
//   mode[1:0]            00 clear, 01 position, 10 attack, 11 reserved
//   coord[5:0]           [5:3] row, [2:0] column
//   ship_hit             position-matrix bit at coord
//   already_shot         attack-matrix bit at coord
//   pos_we / at_we / mat_clr  one-cycle matrix write strobes
//   phase[2:0]           FSM state code
//   result[1:0]          last shot result
//   shots[4:0] hits[5:0] valid shots taken / hits scored
module batalha_ctrl
    import pbl_pkg::*;
#(
    parameter int MAX_SHOTS  = 16,
    parameter int SHIP_CELLS = 7,
    parameter int DEB_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       Nclr,
    input  logic       button_confirmation,
    input  logic [1:0] mode,
    input  logic [5:0] coord,
    input  logic       ship_hit,
    input  logic       already_shot,
    output logic       pos_we,
    output logic       at_we,
    output logic       mat_clr,
    output logic [2:0] phase,
    output logic [1:0] result,
    output logic [4:0] shots,
    output logic [5:0] hits
);

    logic press;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debounce (
        .clk     (clk),
        .Nclr    (Nclr),
        .btn_raw (button_confirmation),
        .press   (press)
    );

    state_t     state, state_n;
    logic       pos_we_n, at_we_n, mat_clr_n;
    logic [1:0] result_n;
    logic [4:0] shots_n;
    logic [5:0] hits_n;
    logic [2:0] row, col;

    assign row   = coord[5:3];
    assign col   = coord[2:0];
    assign phase = state;

    always_ff @(posedge clk or negedge Nclr) begin
        if (!Nclr) begin
            state   <= IDLE;
            pos_we  <= 1'b0;
            at_we   <= 1'b0;
            mat_clr <= 1'b0;
            result  <= RES_NONE;
            shots   <= '0;
            hits    <= '0;
        end else begin
            state   <= state_n;
            pos_we  <= pos_we_n;
            at_we   <= at_we_n;
            mat_clr <= mat_clr_n;
            result  <= result_n;
            shots   <= shots_n;
            hits    <= hits_n;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would infer a latch.
        state_n   = state;
        pos_we_n  = 1'b0;
        at_we_n   = 1'b0;
        mat_clr_n = 1'b0;
        result_n  = result;
        shots_n   = shots;
        hits_n    = hits;

        if (press) begin
            case (mode)
                MODE_CLR: begin
                    mat_clr_n = 1'b1;
                    result_n  = RES_NONE;
                    shots_n   = '0;
                    hits_n    = '0;
                    state_n   = IDLE;
                end
                MODE_POS: begin
                    if (state == IDLE || state == PLACED) begin
                        pos_we_n = 1'b1;
                        state_n  = PLACED;
                    end
                end
                MODE_AT: begin
                    if (state == PLACED) begin
                        if (row > ROW_MAX || col > COL_MAX || already_shot) begin
                            result_n = RES_REJ;
                        end else begin
                            at_we_n = 1'b1;
                            shots_n = shots + 5'd1;
                            if (ship_hit) begin
                                hits_n   = hits + 6'd1;
                                result_n = RES_HIT;
                            end else begin
                                result_n = RES_MISS;
                            end
                            // End-of-game test uses the post-shot counts;
                            // a winning last shot is a win, not a loss.
                            if (hits_n == 6'(SHIP_CELLS)) begin
                                state_n = WIN;
                            end else if (shots_n == 5'(MAX_SHOTS)) begin
                                state_n = LOSE;
                            end
                        end
                    end
                end
                default: ;  // MODE_RSV: ignored in every state
            endcase
        end
    end

endmodule

// File: tb/tb_batalha_ctrl.sv
// tb_batalha_ctrl -- directed self-checking bench for batalha_ctrl.
// Runs with SHIP_CELLS=2, MAX_SHOTS=3, DEB_CYCLES=8; the filter-specific
// cases run only when DEBOUNCE_EN is defined.
module tb_batalha_ctrl;

    localparam int DEB = 8;
`ifdef DEBOUNCE_EN
    localparam int HOLD    = 2 + DEB + 6;
    localparam int LATENCY = 2 + DEB + 2;
`else
    localparam int HOLD    = 6;
    localparam int LATENCY = 4;
`endif

    logic       clk = 1'b0;
    logic       Nclr = 1'b0;
    logic       button_confirmation = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [5:0] coord = 6'd0;
    logic       ship_hit = 1'b0;
    logic       already_shot = 1'b0;
    logic       pos_we, at_we, mat_clr;
    logic [2:0] phase;
    logic [1:0] result;
    logic [4:0] shots;
    logic [5:0] hits;

    int err_cnt = 0;
    int chk_cnt = 0;
    int pos_hi = 0, at_hi = 0, clr_hi = 0;
    int p0, a0, c0;

    batalha_ctrl #(
        .MAX_SHOTS  (3),
        .SHIP_CELLS (2),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk                 (clk),
        .Nclr                (Nclr),
        .button_confirmation (button_confirmation),
        .mode                (mode),
        .coord               (coord),
        .ship_hit            (ship_hit),
        .already_shot        (already_shot),
        .pos_we              (pos_we),
        .at_we               (at_we),
        .mat_clr             (mat_clr),
        .phase               (phase),
        .result              (result),
        .shots               (shots),
        .hits                (hits)
    );

    always #5 clk = ~clk;

    // Cycles each strobe spends high; one press must add exactly 1.
    always @(negedge clk) begin
        if (pos_we)  pos_hi++;
        if (at_we)   at_hi++;
        if (mat_clr) clr_hi++;
    end

    task automatic check(input string tag, input int got, input int exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic snap();
        p0 = pos_hi;
        a0 = at_hi;
        c0 = clr_hi;
    endtask

    task automatic press_btn(input logic [1:0] m, input int r, input int c,
                             input logic hit, input logic shot);
        @(negedge clk);
        snap();
        mode         = m;
        coord        = {r[2:0], c[2:0]};
        ship_hit     = hit;
        already_shot = shot;
        button_confirmation = 1'b1;
        repeat (HOLD) @(negedge clk);
        button_confirmation = 1'b0;
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic check_state(input string tag, input int ph, input int res,
                               input int sh, input int ht,
                               input int dp, input int da, input int dc);
        check({tag, ".phase"},  int'(phase),  ph);
        check({tag, ".result"}, int'(result), res);
        check({tag, ".shots"},  int'(shots),  sh);
        check({tag, ".hits"},   int'(hits),   ht);
        check({tag, ".pos_we"}, pos_hi - p0,  dp);
        check({tag, ".at_we"},  at_hi - a0,   da);
        check({tag, ".clr"},    clr_hi - c0,  dc);
    endtask

    initial begin
        int lat;
        repeat (3) @(negedge clk);
        snap();
        Nclr = 1'b1;
        repeat (2) @(negedge clk);
        check_state("reset", 0, 0, 0, 0, 0, 0, 0);

        press_btn(2'b01, 0, 0, 0, 0);
        check_state("load", 1, 0, 0, 0, 1, 0, 0);
        press_btn(2'b10, 2, 3, 1, 0);
        check_state("hit1", 1, 2, 1, 1, 0, 1, 0);
        press_btn(2'b10, 7, 0, 1, 0);
        check_state("row7", 1, 3, 1, 1, 0, 0, 0);
        press_btn(2'b10, 0, 5, 0, 0);
        check_state("col5", 1, 3, 1, 1, 0, 0, 0);
        press_btn(2'b10, 1, 1, 1, 1);
        check_state("again", 1, 3, 1, 1, 0, 0, 0);
        press_btn(2'b11, 1, 1, 1, 0);
        check_state("rsv", 1, 3, 1, 1, 0, 0, 0);
        press_btn(2'b10, 6, 4, 1, 0);
        check_state("win", 2, 2, 2, 2, 0, 1, 0);
        press_btn(2'b10, 0, 0, 1, 0);
        check_state("win_at", 2, 2, 2, 2, 0, 0, 0);
        press_btn(2'b01, 0, 0, 0, 0);
        check_state("win_pos", 2, 2, 2, 2, 0, 0, 0);
        press_btn(2'b00, 0, 0, 0, 0);
        check_state("clr_win", 0, 0, 0, 0, 0, 0, 1);
        press_btn(2'b10, 0, 0, 1, 0);
        check_state("idle_at", 0, 0, 0, 0, 0, 0, 0);

        press_btn(2'b01, 1, 0, 0, 0);
        check_state("load2", 1, 0, 0, 0, 1, 0, 0);
        press_btn(2'b10, 0, 0, 0, 0);
        check_state("miss1", 1, 1, 1, 0, 0, 1, 0);
        press_btn(2'b10, 0, 1, 0, 0);
        check_state("miss2", 1, 1, 2, 0, 0, 1, 0);
        press_btn(2'b10, 0, 2, 0, 0);
        check_state("lose", 3, 1, 3, 0, 0, 1, 0);
        press_btn(2'b00, 0, 0, 0, 0);
        check_state("clr_lose", 0, 0, 0, 0, 0, 0, 1);

        // Winning on the last allowed shot must be a win.
        press_btn(2'b01, 2, 0, 0, 0);
        press_btn(2'b10, 0, 0, 1, 0);
        press_btn(2'b10, 0, 1, 0, 0);
        press_btn(2'b10, 0, 2, 1, 0);
        check_state("prio", 2, 2, 3, 2, 0, 1, 0);
        press_btn(2'b00, 0, 0, 0, 0);

        // Latency from the input edge to pos_we, over a 20-cycle hold.
        @(negedge clk);
        snap();
        mode = 2'b01;
        lat = -1;
        button_confirmation = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (pos_we && lat < 0) lat = n;
        end
        button_confirmation = 1'b0;
        repeat (HOLD) @(negedge clk);
        check("latency", lat, LATENCY);
        check("hold_once", pos_hi - p0, 1);

`ifdef DEBOUNCE_EN
        // A 5-cycle glitch is shorter than the filter window.
        @(negedge clk);
        snap();
        button_confirmation = 1'b1;
        repeat (5) @(negedge clk);
        button_confirmation = 1'b0;
        repeat (20) @(negedge clk);
        check("glitch", pos_hi - p0, 0);

        // Reset mid-debounce drops the pending press.
        press_btn(2'b00, 0, 0, 0, 0);
        @(negedge clk);
        snap();
        mode = 2'b01;
        button_confirmation = 1'b1;
        repeat (6) @(negedge clk);
        Nclr = 1'b0;
        button_confirmation = 1'b0;
        repeat (2) @(negedge clk);
        Nclr = 1'b1;
        repeat (25) @(negedge clk);
        check("rst_mid", pos_hi - p0, 0);
        check("rst_mid.phase", int'(phase), 0);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
